// File: rtl/if_fetch_stage_if.sv
// Fetch-stage bus bundle: imem request/response channel plus the IF/ID slot toward decode.
// master = fetch stage, slave = imem model / decode side.
interface if_fetch_stage_if #(
  parameter int AddrWidth = 32
);
  logic                 imem_req_valid;
  logic                 imem_req_ready;
  logic [AddrWidth-1:0] imem_req_addr;
  logic                 imem_rsp_valid;
  logic [31:0]          imem_rsp_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [AddrWidth-1:0] out_pc;
  logic [AddrWidth-1:0] out_pc4;
  logic [31:0]          out_instruction;
  logic                 out_fault;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output out_valid, out_pc, out_pc4, out_instruction, out_fault,
    input  out_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  out_valid, out_pc, out_pc4, out_instruction, out_fault,
    output out_ready
  );
endinterface

// File: rtl/if_fetch_stage.sv
// RV32 instruction fetch: one outstanding imem word fetch feeding a single IF/ID slot.
// Optional IF_MISALIGN_TRAP_EN: misaligned redirects produce a faulting NOP entry and stall fetch.
module if_fetch_stage #(
  parameter int                   AddrWidth   = 32,
  parameter logic [AddrWidth-1:0] ResetVector = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  if_fetch_stage_if.master     bus,
  input  logic                 redirect_valid,
  input  logic [AddrWidth-1:0] redirect_pc
);
  localparam logic [31:0] Nop = 32'h0000_0013;

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_DRAIN} state_e;

  state_e               state_q, state_d;
  logic [AddrWidth-1:0] pc_q, pc_plus4, redirect_tgt;
  logic                 req_valid, req_ok, rsp_fill, trap_fill;
  logic                 slot_free, slot_pop;
  logic                 slot_valid_q;
  logic [AddrWidth-1:0] slot_pc_q, slot_pc4_q;
  logic [31:0]          slot_instr_q;

  assign pc_plus4  = pc_q + AddrWidth'(4);
  assign slot_pop  = slot_valid_q && bus.out_ready;
  assign slot_free = !slot_valid_q || bus.out_ready;

`ifdef IF_MISALIGN_TRAP_EN
  logic trap_pend_q, stall_q, fault_q;

  // trap_pend: misaligned redirect seen, faulting entry not yet placed in the slot
  assign redirect_tgt = redirect_pc;
  assign req_ok       = !trap_pend_q && !stall_q;
  assign trap_fill    = (state_q == S_REQ) && trap_pend_q && slot_free && !redirect_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      trap_pend_q <= 1'b0;
      stall_q     <= 1'b0;
    end else if (redirect_valid) begin
      trap_pend_q <= (redirect_pc[1:0] != 2'b00);
      stall_q     <= 1'b0;
    end else if (trap_fill) begin
      trap_pend_q <= 1'b0;
      stall_q     <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                  fault_q <= 1'b0;
    else if (!redirect_valid) begin
      if (rsp_fill)           fault_q <= 1'b0;
      else if (trap_fill)     fault_q <= 1'b1;
    end
  end

  assign bus.out_fault = fault_q;
`else
  assign redirect_tgt  = redirect_pc & ~AddrWidth'(3);
  assign req_ok        = 1'b1;
  assign trap_fill     = 1'b0;
  assign bus.out_fault = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    req_valid = 1'b0;
    rsp_fill  = 1'b0;
    unique case (state_q)
      S_REQ: begin
        // a request only goes out when the slot will be empty by the time data returns
        req_valid = !rst && !redirect_valid && slot_free && req_ok;
        if (req_valid && bus.imem_req_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (redirect_valid)          state_d = bus.imem_rsp_valid ? S_REQ : S_DRAIN;
        else if (bus.imem_rsp_valid) begin
          rsp_fill = 1'b1;
          state_d  = S_REQ;
        end
      end
      S_DRAIN: if (bus.imem_rsp_valid) state_d = S_REQ;
      default: state_d = S_REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_REQ;
      pc_q    <= ResetVector;
    end else begin
      state_q <= state_d;
      if (redirect_valid) pc_q <= redirect_tgt;
      else if (rsp_fill)  pc_q <= pc_plus4;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_valid_q <= 1'b0;
      slot_pc_q    <= '0;
      slot_pc4_q   <= '0;
      slot_instr_q <= Nop;
    end else if (redirect_valid) begin
      slot_valid_q <= 1'b0;
    end else if (rsp_fill) begin
      slot_valid_q <= 1'b1;
      slot_pc_q    <= pc_q;
      slot_pc4_q   <= pc_plus4;
      slot_instr_q <= bus.imem_rsp_data;
    end else if (trap_fill) begin
      slot_valid_q <= 1'b1;
      slot_pc_q    <= pc_q;
      slot_pc4_q   <= pc_plus4;
      slot_instr_q <= Nop;
    end else if (slot_pop) begin
      slot_valid_q <= 1'b0;
    end
  end

  // the issue rule guarantees a returning word never lands on an occupied slot
  always_ff @(posedge clk) begin
    if (!rst && rsp_fill) assert (!slot_valid_q);
  end

  assign bus.imem_req_valid  = req_valid;
  assign bus.imem_req_addr   = pc_q;
  assign bus.out_valid       = slot_valid_q;
  assign bus.out_pc          = slot_pc_q;
  assign bus.out_pc4         = slot_pc4_q;
  assign bus.out_instruction = slot_instr_q;
endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: imem model answers addr^A5A5_0000 after a set delay,
// delivered slot entries are checked against a queue of expected entries.
module tb_if_fetch_stage;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] instr;
    logic        fault;
  } slot_t;

  localparam logic [31:0] Key  = 32'hA5A5_0000;
  localparam logic [31:0] Nop  = 32'h0000_0013;
  localparam logic [31:0] Idle = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  if_fetch_stage_if bus ();

  if_fetch_stage #(.AddrWidth(32), .ResetVector(32'h0000_1000)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  int          checks   = 0;
  int          failures = 0;
  slot_t       exp_q[$];
  int          mem_delay;
  bit          mem_pend;
  int          mem_cnt;
  logic [31:0] mem_addr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] pc, input logic [31:0] instr, input logic fault);
    slot_t e;
    e.pc = pc; e.pc4 = pc + 32'd4; e.instr = instr; e.fault = fault;
    exp_q.push_back(e);
  endtask

  // one clock: scoreboard + imem model at negedge, return 2 time units after the next posedge
  task automatic cyc(input int n = 1);
    slot_t e;
    repeat (n) begin
      @(negedge clk);
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        assert (exp_q.size() != 0) else begin
          failures++;
          $error("FAIL out_extra observed pc=%h expected no entry", bus.out_pc);
        end
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("out_pc", bus.out_pc, e.pc);
          chk("out_pc4", bus.out_pc4, e.pc4);
          chk("out_instruction", bus.out_instruction, e.instr);
          chk("out_fault", 32'(bus.out_fault), 32'(e.fault));
        end
      end
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = Idle;
      if (mem_pend) begin
        if (mem_cnt == 1) begin
          bus.imem_rsp_valid = 1'b1;
          bus.imem_rsp_data  = mem_addr ^ Key;
          mem_pend = 1'b0;
        end else mem_cnt--;
      end
      if (bus.imem_req_valid && bus.imem_req_ready) begin
        mem_pend = 1'b1;
        mem_cnt  = mem_delay;
        mem_addr = bus.imem_req_addr;
      end
      @(posedge clk);
      #2;
    end
  endtask

  task automatic chk_reset();
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_pc", bus.out_pc, 32'd0);
    chk("rst_out_pc4", bus.out_pc4, 32'd0);
    chk("rst_out_instr", bus.out_instruction, Nop);
    chk("rst_out_fault", 32'(bus.out_fault), 32'd0);
    chk("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
  endtask

  initial begin
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    bus.imem_req_ready = 1'b1; bus.imem_rsp_valid = 1'b0; bus.imem_rsp_data = Idle;
    bus.out_ready = 1'b1;
    mem_delay = 1; mem_pend = 1'b0; mem_cnt = 0; mem_addr = '0;

    // 1: reset state, zero-wait streaming from the reset vector
    cyc(2);
    chk_reset();
    rst = 1'b0; #1;
    chk("t1_req_valid", 32'(bus.imem_req_valid), 32'd1);
    chk("t1_req_addr", bus.imem_req_addr, 32'h0000_1000);
    push_exp(32'h0000_1000, 32'h0000_1000 ^ Key, 1'b0);
    push_exp(32'h0000_1004, 32'h0000_1004 ^ Key, 1'b0);
    push_exp(32'h0000_1008, 32'h0000_1008 ^ Key, 1'b0);
    for (int i = 1; i <= 6; i++) begin
      cyc();
      chk("t1_out_valid_cadence", 32'(bus.out_valid), (i % 2 == 0) ? 32'd1 : 32'd0);
    end
    cyc();
    // reset while the 0x100C fetch is outstanding; its response arrives under reset
    rst = 1'b1;
    cyc();
    chk_reset();
    rst = 1'b0; #1;
    chk("rst_mid_req_addr", bus.imem_req_addr, 32'h0000_1000);
    chk("rst_mid_req_valid", 32'(bus.imem_req_valid), 32'd1);

    // 2: decode backpressure holds the slot and blocks the next request
    bus.out_ready = 1'b0;
    push_exp(32'h0000_1000, 32'h0000_1000 ^ Key, 1'b0);
    cyc();
    chk("t2_out_valid_early", 32'(bus.out_valid), 32'd0);
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk("t2_hold_valid", 32'(bus.out_valid), 32'd1);
      chk("t2_hold_pc", bus.out_pc, 32'h0000_1000);
      chk("t2_hold_req_valid", 32'(bus.imem_req_valid), 32'd0);
    end
    cyc();
    bus.out_ready = 1'b1; #1;
    chk("t2_req_on_ready", 32'(bus.imem_req_valid), 32'd1);
    chk("t2_req_addr", bus.imem_req_addr, 32'h0000_1004);
    push_exp(32'h0000_1004, 32'h0000_1004 ^ Key, 1'b0);
    cyc(2);
    mem_delay = 3;

    // 3: redirect in S_WAIT, stale response 3 cycles after acceptance
    cyc();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_2000; #1;
    chk("t3_req_masked", 32'(bus.imem_req_valid), 32'd0);
    cyc();
    redirect_valid = 1'b0; #1;
    chk("t3_out_flushed", 32'(bus.out_valid), 32'd0);
    chk("t3_drain_req0", 32'(bus.imem_req_valid), 32'd0);
    cyc();
    chk("t3_drain_req1", 32'(bus.imem_req_valid), 32'd0);
    cyc();
    chk("t3_req_valid", 32'(bus.imem_req_valid), 32'd1);
    chk("t3_req_addr", bus.imem_req_addr, 32'h0000_2000);
    mem_delay = 1;
    push_exp(32'h0000_2000, 32'h0000_2000 ^ Key, 1'b0);
    cyc(3);

    // 4: redirect coincident with the 0x2004 response, then redirects in S_WAIT and S_DRAIN
    redirect_valid = 1'b1; redirect_pc = 32'h0000_2800;
    cyc();
    redirect_valid = 1'b0; #1;
    chk("t4_req_valid", 32'(bus.imem_req_valid), 32'd1);
    chk("t4_req_addr", bus.imem_req_addr, 32'h0000_2800);
    mem_delay = 3;
    cyc();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_2C00;
    cyc();
    redirect_pc = 32'h0000_3000; #1;
    chk("t4_drain_req0", 32'(bus.imem_req_valid), 32'd0);
    cyc();
    redirect_valid = 1'b0; #1;
    chk("t4_drain_req1", 32'(bus.imem_req_valid), 32'd0);
    cyc();
    chk("t4_req_valid2", 32'(bus.imem_req_valid), 32'd1);
    chk("t4_req_addr2", bus.imem_req_addr, 32'h0000_3000);
    mem_delay = 1;
    push_exp(32'h0000_3000, 32'h0000_3000 ^ Key, 1'b0);
    cyc(2);

    // 5: imem not ready for 4 cycles, then a fetch at the top of the address space
    bus.imem_req_ready = 1'b0; #1;
    chk("t5_req_valid", 32'(bus.imem_req_valid), 32'd1);
    chk("t5_req_addr", bus.imem_req_addr, 32'h0000_3004);
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("t5_stall_req_valid", 32'(bus.imem_req_valid), 32'd1);
      chk("t5_stall_req_addr", bus.imem_req_addr, 32'h0000_3004);
    end
    cyc();
    bus.imem_req_ready = 1'b1;
    push_exp(32'h0000_3004, 32'h0000_3004 ^ Key, 1'b0);
    cyc(2);
    chk("t5_out_valid", 32'(bus.out_valid), 32'd1);
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    cyc();
    redirect_valid = 1'b0; #1;
    chk("t5_top_req_addr", bus.imem_req_addr, 32'hFFFF_FFFC);
    push_exp(32'hFFFF_FFFC, 32'hFFFF_FFFC ^ Key, 1'b0);
    cyc(2);
    chk("t5_wrap_pc4", bus.out_pc4, 32'h0000_0000);
    chk("t5_wrap_req_addr", bus.imem_req_addr, 32'h0000_0000);

    // 6: misaligned redirect
    redirect_valid = 1'b1; redirect_pc = 32'h0000_2002; #1;
    chk("t6_req_masked", 32'(bus.imem_req_valid), 32'd0);
    cyc();
    redirect_valid = 1'b0; #1;
`ifdef IF_MISALIGN_TRAP_EN
    chk("t6_no_req0", 32'(bus.imem_req_valid), 32'd0);
    push_exp(32'h0000_2002, Nop, 1'b1);
    cyc();
    chk("t6_trap_valid", 32'(bus.out_valid), 32'd1);
    chk("t6_trap_fault", 32'(bus.out_fault), 32'd1);
    chk("t6_trap_pc", bus.out_pc, 32'h0000_2002);
    chk("t6_no_req1", 32'(bus.imem_req_valid), 32'd0);
    cyc();
    chk("t6_stall_req", 32'(bus.imem_req_valid), 32'd0);
    chk("t6_stall_out", 32'(bus.out_valid), 32'd0);
    cyc();
    chk("t6_stall_req2", 32'(bus.imem_req_valid), 32'd0);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_2004;
    cyc();
    redirect_valid = 1'b0; #1;
    chk("t6_resume_valid", 32'(bus.imem_req_valid), 32'd1);
    chk("t6_resume_addr", bus.imem_req_addr, 32'h0000_2004);
    push_exp(32'h0000_2004, 32'h0000_2004 ^ Key, 1'b0);
`else
    chk("t6_align_valid", 32'(bus.imem_req_valid), 32'd1);
    chk("t6_align_addr", bus.imem_req_addr, 32'h0000_2000);
    push_exp(32'h0000_2000, 32'h0000_2000 ^ Key, 1'b0);
`endif
    cyc(2);
    chk("t6_final_out_valid", 32'(bus.out_valid), 32'd1);
    cyc();
    bus.out_ready = 1'b0;
    cyc(4);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
